// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the keypad-calculator ALU sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 2;
    localparam int unsigned OP_W       = 2;
    localparam int unsigned KEY_W      = 4;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEYWR = 3'd1,
        READ  = 3'd2,
        WB    = 3'd3,
        RESP  = 3'd4
    } state_e;

    typedef enum logic {
        KEY = 1'b0,
        CMD = 1'b1
    } owner_e;

endpackage

// File: rtl/alu_sequencer_arb.sv
// Two-requester arbiter; on a tie the requester not granted last wins.
module seq_arb
    import alu_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_key,
    input  logic req_cmd,
    input  logic enable,
    output logic gnt_key,
    output logic gnt_cmd
);

    owner_e r_last_grant;

    always_comb begin
        gnt_key = 1'b0;
        gnt_cmd = 1'b0;
        if (enable) begin
            if (req_key && req_cmd) begin
                gnt_key = (r_last_grant == CMD);
                gnt_cmd = (r_last_grant == KEY);
            end else begin
                gnt_key = req_key;
                gnt_cmd = req_cmd;
            end
        end
    end

    // Reset to CMD so the very first tie goes to the keypad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= CMD;
        end else if (gnt_key) begin
            r_last_grant <= KEY;
        end else if (gnt_cmd) begin
            r_last_grant <= CMD;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences register-bank writes from the keypad and ALU commands; returns ALU results on a valid/ready port.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [KEY_W-1:0]  key_code,
    input  logic [ADDR_W-1:0] key_dst,
    output logic              key_ready,
    input  logic              cmd_valid,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic              cmd_wb,
    output logic              cmd_ready,
    output logic [ADDR_W-1:0] rf_addr_a,
    output logic [ADDR_W-1:0] rf_addr_b,
    output logic [ADDR_W-1:0] rf_addr_wr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero,
    input  logic              rsp_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  cmd_count
);

    state_e            r_state, w_state_nxt;
    logic              w_idle, w_gnt_key, w_gnt_cmd;
    logic [ADDR_W-1:0] r_dst, w_dst_nxt;
    logic              r_wb, w_wb_nxt;
    logic [DATA_W-1:0] r_res, w_res_nxt;
    logic              r_carry, w_carry_nxt, r_zero, w_zero_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr_a, w_addr_a_nxt, r_addr_b, w_addr_b_nxt;
    logic [ADDR_W-1:0] r_addr_wr, w_addr_wr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_we, w_we_nxt;
    logic [OP_W-1:0]   r_sel, w_sel_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic              r_busy, w_busy_nxt;

    assign w_idle = (r_state == IDLE);

    seq_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_key (key_valid),
        .req_cmd (cmd_valid),
        .enable  (w_idle),
        .gnt_key (w_gnt_key),
        .gnt_cmd (w_gnt_cmd)
    );

    // Next state plus next values of the registered datapath-control outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_dst_nxt       = r_dst;
        w_wb_nxt        = r_wb;
        w_res_nxt       = r_res;
        w_carry_nxt     = r_carry;
        w_zero_nxt      = r_zero;
        w_cnt_nxt       = r_cnt;
        w_addr_a_nxt    = '0;
        w_addr_b_nxt    = '0;
        w_addr_wr_nxt   = '0;
        w_wdata_nxt     = '0;
        w_we_nxt        = 1'b0;
        w_sel_nxt       = '0;
        w_rsp_valid_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_key) begin
                    w_state_nxt   = KEYWR;
                    w_we_nxt      = 1'b1;
                    w_addr_wr_nxt = key_dst;
                    w_wdata_nxt   = DATA_W'(key_code);
                end else if (w_gnt_cmd) begin
                    w_state_nxt  = READ;
                    w_dst_nxt    = cmd_dst;
                    w_wb_nxt     = cmd_wb;
                    w_addr_a_nxt = cmd_src_a;
                    w_addr_b_nxt = cmd_src_b;
                    w_sel_nxt    = cmd_op;
                end
            end
            KEYWR: w_state_nxt = IDLE;
            READ: begin
                w_state_nxt   = WB;
                w_res_nxt     = alu_out;
                w_carry_nxt   = alu_carry;
                w_zero_nxt    = alu_zero;
                w_we_nxt      = r_wb;
                w_addr_wr_nxt = r_dst;
                w_wdata_nxt   = alu_out;
            end
            WB: begin
                w_state_nxt     = RESP;
                w_rsp_valid_nxt = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_dst       <= '0;
            r_wb        <= 1'b0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_cnt       <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_addr_wr   <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dst       <= w_dst_nxt;
            r_wb        <= w_wb_nxt;
            r_res       <= w_res_nxt;
            r_carry     <= w_carry_nxt;
            r_zero      <= w_zero_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr_a    <= w_addr_a_nxt;
            r_addr_b    <= w_addr_b_nxt;
            r_addr_wr   <= w_addr_wr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_we        <= w_we_nxt;
            r_sel       <= w_sel_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign key_ready  = w_gnt_key;
    assign cmd_ready  = w_gnt_cmd;
    assign rf_addr_a  = r_addr_a;
    assign rf_addr_b  = r_addr_b;
    assign rf_addr_wr = r_addr_wr;
    assign rf_wdata   = r_wdata;
    assign rf_we      = r_we;
    assign alu_sel    = r_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_res;
    assign rsp_carry  = r_carry;
    assign rsp_zero   = r_zero;
    assign busy       = r_busy;
    assign cmd_count  = r_cnt;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a stand-in register bank and ALU, table vectors and a random scoreboard run.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid, key_ready, cmd_valid, cmd_ready, cmd_wb;
    logic [3:0] key_code;
    logic [1:0] key_dst, cmd_op, cmd_src_a, cmd_src_b, cmd_dst;
    logic [1:0] rf_addr_a, rf_addr_b, rf_addr_wr, alu_sel;
    logic [7:0] rf_wdata, alu_out, rsp_data, cmd_count;
    logic       rf_we, alu_carry, alu_zero, rsp_valid, rsp_carry, rsp_zero, rsp_ready, busy;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_code(key_code), .key_dst(key_dst), .key_ready(key_ready),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_dst(cmd_dst), .cmd_wb(cmd_wb), .cmd_ready(cmd_ready),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_addr_wr(rf_addr_wr),
        .rf_wdata(rf_wdata), .rf_we(rf_we), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_ready(rsp_ready), .busy(busy), .cmd_count(cmd_count)
    );

    // Stand-in register bank and ALU (00 add, 01 sub with borrow, 10 and, 11 xor).
    logic [7:0] rf [4];
    logic [7:0] w_ra, w_rb;
    logic [8:0] w_res;

    always @(posedge clk) if (rf_we) rf[rf_addr_wr] <= rf_wdata;

    always_comb begin
        w_ra  = rf[rf_addr_a];
        w_rb  = rf[rf_addr_b];
        w_res = 9'h000;
        case (alu_sel)
            2'b00:   w_res = {1'b0, w_ra} + {1'b0, w_rb};
            2'b01:   w_res = {1'b0, w_ra} - {1'b0, w_rb};
            2'b10:   w_res = {1'b0, w_ra & w_rb};
            default: w_res = {1'b0, w_ra ^ w_rb};
        endcase
    end
    assign alu_out   = w_res[7:0];
    assign alu_carry = w_res[8];
    assign alu_zero  = (w_res[7:0] == 8'h00);

    int         n_checks = 0;
    int         n_err = 0;
    int         m_cnt = 0;
    logic [7:0] m_rf [4];
    logic [7:0] last_d;
    logic       last_c, last_z;

    typedef struct {
        bit         is_key;
        logic [3:0] code;
        logic [1:0] op, a, b, dst;
        logic       wb;
        int         hold;
        logic [7:0] exp_d;
        logic       exp_c, exp_z;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input int is_key, input int code, input int op, input int a, input int b,
                                input int dst, input int wb, input int hold, input int d, input int c, input int z);
        vec_t v;
        v.is_key = (is_key != 0);
        v.code   = 4'(code);
        v.op     = 2'(op);
        v.a      = 2'(a);
        v.b      = 2'(b);
        v.dst    = 2'(dst);
        v.wb     = 1'(wb);
        v.hold   = hold;
        v.exp_d  = 8'(d);
        v.exp_c  = 1'(c);
        v.exp_z  = 1'(z);
        return v;
    endfunction

    // Reference ALU in plain integer arithmetic.
    function automatic void ref_alu(input int op, input int a, input int b, output int d, output int c, output int z);
        d = 0;
        c = 0;
        case (op)
            0: begin d = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin d = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: d = a & b;
            default: d = a ^ b;
        endcase
        z = (d == 0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_grant(input bit is_key, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (is_key ? key_ready : cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_key(input logic [3:0] code, input logic [1:0] dst);
        bit ok;
        key_code  = code;
        key_dst   = dst;
        key_valid = 1'b1;
        wait_grant(1'b1, ok);
        check("key_grant", 32'(ok), 1);
        if (!ok) begin
            key_valid = 1'b0;
            @(negedge clk);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        check("key_ready_busy", 32'(key_ready), 0);
        key_valid = 1'b0;
        check("key_we", 32'(rf_we), 1);
        check("key_addr", 32'(rf_addr_wr), 32'(dst));
        check("key_wdata", 32'(rf_wdata), 32'({4'h0, code}));
        check("key_busy", 32'(busy), 1);
        @(negedge clk);
        check("key_we_off", 32'(rf_we), 0);
        check("key_busy_off", 32'(busy), 0);
        m_rf[dst] = {4'h0, code};
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                            input logic [1:0] dst, input logic wb, input int hold);
        bit ok;
        int ed, ec, ez;
        ref_alu(32'(op), 32'(m_rf[a]), 32'(m_rf[b]), ed, ec, ez);
        cmd_op    = op;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dst   = dst;
        cmd_wb    = wb;
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        wait_grant(1'b0, ok);
        check("cmd_grant", 32'(ok), 1);
        if (!ok) begin
            cmd_valid = 1'b0;
            @(negedge clk);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        check("rd_cmd_ready", 32'(cmd_ready), 0);
        cmd_valid = 1'b0;
        check("rd_addr_a", 32'(rf_addr_a), 32'(a));
        check("rd_addr_b", 32'(rf_addr_b), 32'(b));
        check("rd_sel", 32'(alu_sel), 32'(op));
        check("rd_we", 32'(rf_we), 0);
        check("rd_rsp_valid", 32'(rsp_valid), 0);
        check("rd_busy", 32'(busy), 1);
        @(negedge clk);
        check("wb_we", 32'(rf_we), 32'(wb));
        if (wb) begin
            check("wb_addr", 32'(rf_addr_wr), 32'(dst));
            check("wb_wdata", 32'(rf_wdata), ed);
        end
        check("wb_sel", 32'(alu_sel), 0);
        check("wb_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_data", 32'(rsp_data), ed);
            check("hold_flags", 32'({rsp_carry, rsp_zero}), 32'({ec[0], ez[0]}));
            check("hold_cnt", 32'(cmd_count), m_cnt % 256);
            check("hold_we", 32'(rf_we), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_data", 32'(rsp_data), ed);
        check("rsp_carry", 32'(rsp_carry), ec);
        check("rsp_zero", 32'(rsp_zero), ez);
        last_d = rsp_data;
        last_c = rsp_carry;
        last_z = rsp_zero;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_cnt++;
        if (wb) m_rf[dst] = 8'(ed);
        check("done_valid", 32'(rsp_valid), 0);
        check("done_busy", 32'(busy), 0);
        check("done_cnt", 32'(cmd_count), m_cnt % 256);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int ng;
        key_valid = 1'b0; key_code = 4'h0; key_dst = 2'd0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_dst = 2'd0; cmd_wb = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rf[i]   = 8'h00;
            m_rf[i] = 8'h00;
        end

        tbl[0] = mk(1, 5, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        tbl[1] = mk(1, 3, 0, 0, 0, 2, 0, 0, 8'h00, 0, 0);
        tbl[2] = mk(0, 0, 0, 1, 2, 3, 1, 0, 8'h08, 0, 0);
        tbl[3] = mk(0, 0, 1, 1, 2, 0, 0, 5, 8'h02, 0, 0);
        tbl[4] = mk(0, 0, 1, 2, 1, 0, 0, 1, 8'hFE, 1, 0);
        tbl[5] = mk(0, 0, 0, 3, 3, 3, 1, 0, 8'h10, 0, 0);
        tbl[6] = mk(0, 0, 2, 3, 1, 0, 1, 0, 8'h00, 0, 1);
        tbl[7] = mk(0, 0, 3, 1, 2, 0, 1, 2, 8'h06, 0, 0);
        tbl[8] = mk(1, 15, 0, 0, 0, 2, 0, 0, 8'h00, 0, 0);
        tbl[9] = mk(0, 0, 0, 3, 2, 1, 1, 0, 8'h1F, 0, 0);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_we", 32'(rf_we), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'(cmd_count), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_readys", 32'({key_ready, cmd_ready}), 0);
        check("rst_addrs", 32'({rf_addr_a, rf_addr_b, rf_addr_wr, alu_sel}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].is_key) begin
                send_key(tbl[i].code, tbl[i].dst);
            end else begin
                send_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dst, tbl[i].wb, tbl[i].hold);
                check("tbl_data", 32'(last_d), 32'(tbl[i].exp_d));
                check("tbl_carry", 32'(last_c), 32'(tbl[i].exp_c));
                check("tbl_zero", 32'(last_z), 32'(tbl[i].exp_z));
                if (tbl[i].wb) check("tbl_rf", 32'(rf[tbl[i].dst]), 32'(tbl[i].exp_d));
            end
        end

        // Reset in the middle of a write-back cycle must suppress the write.
        cmd_op = 2'd0; cmd_src_a = 2'd1; cmd_src_b = 2'd2; cmd_dst = 2'd2; cmd_wb = 1'b1;
        cmd_valid = 1'b1;
        wait_grant(1'b0, ok);
        check("mwb_grant", 32'(ok), 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mwb_we", 32'(rf_we), 0);
        check("mwb_wr", 32'({rf_addr_wr, rf_wdata}), 0);
        check("mwb_busy", 32'(busy), 0);
        check("mwb_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        @(negedge clk);
        check("mwb_rf_kept", 32'(rf[2]), 32'(m_rf[2]));
        check("mwb_busy_after", 32'(busy), 0);
        check("mwb_no_rsp", 32'(rsp_valid), 0);
        check("mwb_cnt", 32'(cmd_count), 0);

        // Both requesters held: grants alternate starting with key.
        key_code = 4'hA; key_dst = 2'd1; key_valid = 1'b1;
        cmd_op = 2'd0; cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_dst = 2'd0; cmd_wb = 1'b0; cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        ng = 0;
        for (int i = 0; i < 24; i++) begin
            #1;
            check("alt_excl", 32'(key_ready & cmd_ready), 0);
            if (key_ready || cmd_ready) begin
                check("alt_order", 32'(cmd_ready), ng % 2);
                if (key_ready) m_rf[1] = 8'h0A;
                else m_cnt++;
                ng++;
            end
            @(negedge clk);
        end
        key_valid = 1'b0;
        cmd_valid = 1'b0;
        check("alt_grants", ng, 8);
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        check("alt_cnt", 32'(cmd_count), m_cnt % 256);
        check("alt_idle", 32'(busy), 0);
        check("alt_rf1", 32'(rf[1]), 32'(m_rf[1]));

        // Random traffic until the command counter wraps.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        @(negedge clk);
        for (int it = 0; it < 3000 && m_cnt < 256; it++) begin
            if ($urandom_range(0, 2) == 0)
                send_key(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            else
                send_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        check("wrap_total", m_cnt, 256);
        check("wrap_cnt", 32'(cmd_count), 0);
        for (int i = 0; i < 4; i++) check("final_rf", 32'(rf[i]), 32'(m_rf[i]));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven controller that sequences the 4×8 register bank and the 2-bit-op ALU of the keypad calculator datapath. It arbitrates the register bank write port between the keypad encoder and an ALU command stream, and drives the register read addresses and the ALU select. Results are returned on a valid/ready response port. It sits between the top-level pin decode and the existing register bank / ALU instances.

## Interface
Parameters:
- DATA_W, 8, datapath width (register bank word, ALU operands/result)
- ADDR_W, 2, register address width (4 registers)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  keypad code available
- key_code  in  4  keypad hex code
- key_dst  in  ADDR_W  destination register for key code
- key_ready  out  1  key accepted this cycle (valid & ready at edge)
- cmd_valid  in  1  ALU command available
- cmd_op  in  2  ALU select, passed through undecoded
- cmd_src_a, cmd_src_b  in  ADDR_W  operand registers
- cmd_dst  in  ADDR_W  write-back register
- cmd_wb  in  1  1 = write result back to cmd_dst
- cmd_ready  out  1  command accepted this cycle
- rf_addr_a, rf_addr_b  out  ADDR_W  register bank read addresses
- rf_addr_wr  out  ADDR_W  register bank write address
- rf_wdata  out  DATA_W  register bank write data
- rf_we  out  1  register bank write enable
- alu_sel  out  2  ALU operation select
- alu_out  in  DATA_W  ALU result (combinational from rf read data)
- alu_carry, alu_zero  in  1  ALU flags
- rsp_valid  out  1  result available
- rsp_data  out  DATA_W  captured ALU result
- rsp_carry, rsp_zero  out  1  captured flags
- rsp_ready  in  1  consumer accepts response
- busy  out  1  state ≠ IDLE
- cmd_count  out  8  completed-command counter

## Operation
- States: IDLE, KEYWR, READ, WB, RESP.
- IDLE: key_ready and cmd_ready are combinational grants; at most one high per cycle.
  - Only one requester valid → it is granted.
  - Both valid → grant goes to the requester not granted last (last_grant flag; reset value = CMD, so the first tie goes to key).
- Key grant → KEYWR: rf_we=1, rf_addr_wr=latched key_dst, rf_wdata={0, key_code} (zero-extended to DATA_W). → IDLE.
- Cmd grant → latch op/src/dst/wb; READ: rf_addr_a/b = latched srcs, alu_sel = latched op; at the edge, capture alu_out/carry/zero into the result registers. → WB.
- WB: rf_we = latched cmd_wb, rf_addr_wr = latched dst, rf_wdata = result. → RESP.
- RESP: rsp_valid=1, rsp_* = result registers, held stable until rsp_ready is sampled high. Then cmd_count increments (wraps 255→0) → IDLE.
- src = dst is legal: the operands are read in READ and the write occurs in WB, so there is no hazard.
- Outside their owning states: rf_we=0, rf_addr_*=0, rf_wdata=0, alu_sel=0.

## Timing
- Reset (async assert, sync-safe deassert on clk): state=IDLE, last_grant=CMD, all outputs 0, latched command discarded, no write issued. Reset in any state aborts without rf_we.
- Key write: accept edge E0 → rf_we high for exactly one cycle after E0. Throughput is 1 key per 2 cycles.
- Command: accept edge E0 → READ cycle → WB cycle (rf_we one cycle if wb) → rsp_valid rises 2 cycles after E0.
- rsp_ready high already on the first RESP cycle → minimum command occupancy is 3 cycles; next grant is possible in the cycle after.
- key_ready/cmd_ready are 0 in every non-IDLE state; requesters must hold valid and data until ready.

## Structure
- Package alu_seq_pkg: state enum (IDLE, KEYWR, READ, WB, RESP), grant-owner enum (KEY, CMD), DATA_W/ADDR_W defaults.
- One sub-module, seq_arb: 2-requester alternating-priority arbiter (req_key, req_cmd, enable=IDLE → gnt_key, gnt_cmd, last_grant flop).

## Test plan
Bench instantiates this block with the team's register bank and ALU.
- Reset mid-WB with cmd_wb=1 → rf_we never asserted; outputs 0; busy=0 next cycle.
- Key 0x5→r1, then 0x3→r2 → rf_we pulses at addr 1 data 0x05 and at addr 2 data 0x03; key_ready high one cycle each.
- Cmd op=00 (ADD), a=r1, b=r2, dst=r3, wb=1 → rsp_valid 2 cycles after accept, rsp_data=0x08, rsp_zero=0; r3 reads 0x08.
- Cmd wb=0, rsp_ready held low 5 cycles → rf_we stays 0; rsp_* stable for the full 5 cycles; cmd_count increments only on the ready edge.
- key_valid and cmd_valid held continuously → grants alternate key, cmd, key, cmd starting with key; neither requester starves.
- 256 completed commands → cmd_count wraps to 0x00.
